// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared types and constants for the MIPS pipeline stages
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int          IF_ID_W          = 65;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
    } if_id_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
//------------------------------------------------------------------------------
// if_id_reg : generic pipeline register, load enable plus synchronous clear
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Clear takes precedence so a squash is never overridden by a load.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage : PC, valid/ready instruction fetch and IF/ID register
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  pc_inc;

    logic         ifid_load;
    logic         ifid_clr;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_inc = pc_plus4(pc_q);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        tgt_d          = tgt_q;
        buf_d          = buf_q;
        ifid_load      = 1'b0;
        ifid_clr       = 1'b0;
        ifid_d.valid   = 1'b1;
        ifid_d.inst    = imem_rdata;
        ifid_d.pc4     = pc_inc;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        pc_d     = redirect_pc;
                        ifid_clr = 1'b1;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_inc;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request still outstanding: remember target, finish the old access first.
                    tgt_d    = redirect_pc;
                    ifid_clr = 1'b1;
                    state_d  = DRAIN;
                end
            end
            HOLD: begin
                ifid_d.inst = buf_q;
                if (redirect_valid) begin
                    pc_d     = redirect_pc;
                    ifid_clr = 1'b1;
                    state_d  = FETCH;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    tgt_d    = redirect_pc;
                    ifid_clr = 1'b1;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redirect_pc : tgt_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            buf_q   <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg #(
        .WIDTH (IF_ID_W)
    ) u_if_id_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (ifid_clr),
        .load (ifid_load),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign imem_req    = rst && (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign if_id_valid = ifid_q.valid;
    assign if_id_inst  = ifid_q.inst;
    assign if_id_pc4   = ifid_q.pc4;

endmodule

`default_nettype wire
